// File: rtl/half_adder_serial_sched_if.sv
// Request/response bundle between client logic and the shared bit-serial adder.
// master = client side (drives requests, consumes responses); slave = scheduler.
interface half_adder_serial_sched_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_carry;
    logic             rsp_id;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_sum, rsp_carry, rsp_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_sum, rsp_carry, rsp_id, busy
    );
endinterface

// File: rtl/half_adder_serial_sched.sv
// Round-robin scheduler sharing one bit-serial full adder (two half adders plus
// carry OR) between two requesters. Operands are added LSB-first over WIDTH
// cycles; the result is returned on a valid/ready port tagged with the owner id.
module half_adder_serial_sched #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    half_adder_serial_sched_if.slave     bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               last_grant_reg;
    logic [WIDTH-1:0]   op_a_reg;
    logic [WIDTH-1:0]   op_b_reg;
    logic [WIDTH-1:0]   sum_sh_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   bit_idx_reg;
    logic [WIDTH-1:0]   rsp_sum_reg;
    logic               rsp_carry_reg;
    logic               rsp_id_reg;

    logic               grant_valid;
    logic               grant_id;
    logic               accept;
    logic               rsp_hs;
    logic               last_bit;
    logic               h1, c1, s, c2, carry_next;

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_valid = bus.req0_valid || bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            grant_id = ~last_grant_reg;
        else
            grant_id = ~bus.req0_valid;
    end

    assign accept   = (state_reg == ST_IDLE) && grant_valid;
    assign rsp_hs   = (state_reg == ST_DONE) && bus.rsp_ready;
    assign last_bit = (bit_idx_reg == CNT_W'(WIDTH - 1));

    // One full-adder bit: first half adder on the operand bits, second adds carry-in.
    always_comb begin
        h1         = op_a_reg[0] ^ op_b_reg[0];
        c1         = op_a_reg[0] & op_b_reg[0];
        s          = h1 ^ carry_reg;
        c2         = h1 & carry_reg;
        carry_next = c1 | c2;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic: accept -> serial run of WIDTH bits -> hold until consumed.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)   state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE: if (rsp_hs)   state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // Outputs: readies are combinational from valid and state, never both high.
    always_comb begin
        bus.req0_ready = (state_reg == ST_IDLE) && grant_valid && !grant_id;
        bus.req1_ready = (state_reg == ST_IDLE) && grant_valid &&  grant_id;
        bus.rsp_valid  = (state_reg == ST_DONE);
        bus.busy       = (state_reg != ST_IDLE);
        bus.rsp_sum    = rsp_sum_reg;
        bus.rsp_carry  = rsp_carry_reg;
        bus.rsp_id     = rsp_id_reg;
    end

    // Datapath: latch operands on accept, shift one bit per RUN cycle, and publish
    // the result only on the final bit so the response holds its old value until DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant_reg <= 1'b1;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            sum_sh_reg     <= '0;
            carry_reg      <= 1'b0;
            bit_idx_reg    <= '0;
            rsp_sum_reg    <= '0;
            rsp_carry_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
        end else if (accept) begin
            op_a_reg       <= grant_id ? bus.req1_a : bus.req0_a;
            op_b_reg       <= grant_id ? bus.req1_b : bus.req0_b;
            last_grant_reg <= grant_id;
            rsp_id_reg     <= grant_id;
            carry_reg      <= 1'b0;
            bit_idx_reg    <= '0;
        end else if (state_reg == ST_RUN) begin
            op_a_reg    <= op_a_reg >> 1;
            op_b_reg    <= op_b_reg >> 1;
            sum_sh_reg  <= {s, sum_sh_reg[WIDTH-1:1]};
            carry_reg   <= carry_next;
            bit_idx_reg <= bit_idx_reg + CNT_W'(1);
            if (last_bit) begin
                rsp_sum_reg   <= {s, sum_sh_reg[WIDTH-1:1]};
                rsp_carry_reg <= carry_next;
            end
        end
    end
endmodule
